// File: rtl/vfu_response_demux_if.sv
// Response-path bundle between the shared VFU and the per-slot response queues.
// The demux takes the slave side; the VFU/lane-slot side uses master.
interface vfu_response_demux_if #(
    parameter int TAG_NUM = 4,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 2
);
    logic                        io_in_valid;
    logic                        io_in_ready;
    logic [DATA_W-1:0]           io_in_bits_data;
    logic [1:0]                  io_in_bits_tag;
    logic [1:0]                  io_in_bits_executeIndex;
    logic                        io_in_bits_vxsat;
    logic [4:0]                  io_in_bits_exceptionFlags;
    logic [TAG_NUM-1:0]          io_out_valid;
    logic [TAG_NUM-1:0]          io_out_ready;
    logic [TAG_NUM*DATA_W-1:0]   io_out_bits_data;
    logic [TAG_NUM*2-1:0]        io_out_bits_executeIndex;
    logic [TAG_NUM-1:0]          io_out_bits_vxsat;
    logic [TAG_NUM*5-1:0]        io_out_bits_exceptionFlags;
    logic [TAG_NUM*CNT_W-1:0]    io_count;
    logic                        io_tagError;

    modport slave (
        input  io_in_valid, io_in_bits_data, io_in_bits_tag, io_in_bits_executeIndex,
               io_in_bits_vxsat, io_in_bits_exceptionFlags, io_out_ready,
        output io_in_ready, io_out_valid, io_out_bits_data, io_out_bits_executeIndex,
               io_out_bits_vxsat, io_out_bits_exceptionFlags, io_count, io_tagError
    );

    modport master (
        output io_in_valid, io_in_bits_data, io_in_bits_tag, io_in_bits_executeIndex,
               io_in_bits_vxsat, io_in_bits_exceptionFlags, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_bits_data, io_out_bits_executeIndex,
               io_out_bits_vxsat, io_out_bits_exceptionFlags, io_count, io_tagError
    );
endinterface

// File: rtl/vfu_response_demux.sv
// Steers VFU responses by tag into per-slot FIFOs drained by independent valid/ready consumers.
// Optional VFU_RESP_BYPASS_EN: an empty, ready slot receives the response combinationally.
module vfu_response_demux #(
    parameter int TAG_NUM = 4,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    vfu_response_demux_if.slave  io
);
    localparam int          PTR_W   = $clog2(DEPTH);
    localparam int          ENTRY_W = DATA_W + 8;
    localparam logic [2:0]  TAG_LIM = 3'(TAG_NUM);

    logic [ENTRY_W-1:0] mem_r   [TAG_NUM][DEPTH];
    logic [PTR_W-1:0]   wptr_r  [TAG_NUM];
    logic [PTR_W-1:0]   rptr_r  [TAG_NUM];
    logic [CNT_W-1:0]   count_r [TAG_NUM];
    logic               tag_error_r;

    logic               tag_valid_s;
    logic [TAG_NUM-1:0] tag_hit_s;
    logic [TAG_NUM-1:0] full_s;
    logic [TAG_NUM-1:0] enq_s;
    logic [TAG_NUM-1:0] deq_s;
    logic [TAG_NUM-1:0] byp_s;
    logic [ENTRY_W-1:0] in_entry_s;

    assign tag_valid_s = ({1'b0, io.io_in_bits_tag} < TAG_LIM);
    assign in_entry_s  = {io.io_in_bits_data, io.io_in_bits_executeIndex,
                          io.io_in_bits_vxsat, io.io_in_bits_exceptionFlags};

    // Per-slot tag decode, full/bypass detection and enqueue/dequeue strobes
    always_comb begin
        tag_hit_s = '0;
        full_s    = '0;
        enq_s     = '0;
        deq_s     = '0;
        byp_s     = '0;
        for (int i = 0; i < TAG_NUM; i++) begin
            tag_hit_s[i] = tag_valid_s && (io.io_in_bits_tag == 2'(i));
            full_s[i]    = (count_r[i] == CNT_W'(DEPTH));
            deq_s[i]     = (count_r[i] != '0) && io.io_out_ready[i];
`ifdef VFU_RESP_BYPASS_EN
            byp_s[i]     = io.io_in_valid && tag_hit_s[i] && (count_r[i] == '0) && io.io_out_ready[i];
`else
            byp_s[i]     = 1'b0;
`endif
            enq_s[i]     = io.io_in_valid && tag_hit_s[i] && !full_s[i] && !byp_s[i];
        end
    end

    // Full check deliberately ignores a same-cycle dequeue so ready depends on the tag only
    assign io.io_in_ready = !tag_valid_s || !(|(tag_hit_s & full_s));

    // Queue storage; contents are only observable through the gated head below
    always_ff @(posedge clock) begin
        for (int i = 0; i < TAG_NUM; i++) begin
            if (enq_s[i]) begin
                mem_r[i][wptr_r[i]] <= in_entry_s;
            end
        end
    end

    // Pointers, occupancy counters and sticky tag error
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < TAG_NUM; i++) begin
                wptr_r[i]  <= '0;
                rptr_r[i]  <= '0;
                count_r[i] <= '0;
            end
            tag_error_r <= 1'b0;
        end else begin
            for (int i = 0; i < TAG_NUM; i++) begin
                if (enq_s[i]) begin
                    wptr_r[i] <= wptr_r[i] + PTR_W'(1);
                end
                if (deq_s[i]) begin
                    rptr_r[i] <= rptr_r[i] + PTR_W'(1);
                end
                count_r[i] <= count_r[i] + CNT_W'(enq_s[i]) - CNT_W'(deq_s[i]);
            end
            if (io.io_in_valid && !tag_valid_s) begin
                tag_error_r <= 1'b1;
            end
        end
    end

    logic [TAG_NUM-1:0]        out_valid_s;
    logic [TAG_NUM*DATA_W-1:0] out_data_s;
    logic [TAG_NUM*2-1:0]      out_ei_s;
    logic [TAG_NUM-1:0]        out_vx_s;
    logic [TAG_NUM*5-1:0]      out_fl_s;
    logic [TAG_NUM*CNT_W-1:0]  count_s;
    logic [ENTRY_W-1:0]        head_s;

    // Head selection; an empty slot presents all-zero fields
    always_comb begin
        out_valid_s = '0;
        out_data_s  = '0;
        out_ei_s    = '0;
        out_vx_s    = '0;
        out_fl_s    = '0;
        count_s     = '0;
        head_s      = '0;
        for (int i = 0; i < TAG_NUM; i++) begin
            if (byp_s[i]) begin
                head_s = in_entry_s;
            end else if (count_r[i] != '0) begin
                head_s = mem_r[i][rptr_r[i]];
            end else begin
                head_s = '0;
            end
            out_valid_s[i]                = (count_r[i] != '0) || byp_s[i];
            out_data_s[i*DATA_W +: DATA_W] = head_s[ENTRY_W-1 -: DATA_W];
            out_ei_s[i*2 +: 2]            = head_s[7:6];
            out_vx_s[i]                   = head_s[5];
            out_fl_s[i*5 +: 5]            = head_s[4:0];
            count_s[i*CNT_W +: CNT_W]     = count_r[i];
        end
    end

    assign io.io_out_valid               = out_valid_s;
    assign io.io_out_bits_data           = out_data_s;
    assign io.io_out_bits_executeIndex   = out_ei_s;
    assign io.io_out_bits_vxsat          = out_vx_s;
    assign io.io_out_bits_exceptionFlags = out_fl_s;
    assign io.io_count                   = count_s;
    assign io.io_tagError                = tag_error_r;
endmodule

// File: tb/tb_vfu_response_demux.sv
// Scoreboard bench for vfu_response_demux with three slots so tag 3 is an invalid tag.
// Expected contents are kept as plain per-slot queues; driver and monitors are separate processes.
module tb_vfu_response_demux;
    localparam int TN = 3;
    localparam int DW = 32;
    localparam int DEPTH = 2;
    localparam int CW = 2;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  ei;
        logic        vx;
        logic [4:0]  fl;
    } entry_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    vfu_response_demux_if #(.TAG_NUM(TN), .DATA_W(DW), .CNT_W(CW)) bus ();

    vfu_response_demux #(.TAG_NUM(TN), .DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clock (clock),
        .reset (reset),
        .io    (bus)
    );

    entry_t exp_q [TN][$];
    bit     tag_err_exp = 1'b0;
    bit     model_ok = 1'b0;
    int     n_cmp = 0;
    int     n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input bit rst_low, input bit v, input logic [1:0] t,
                         input logic [31:0] d, input logic [2:0] r);
        @(negedge clock);
        reset = !rst_low;
        bus.io_in_valid = v;
        bus.io_in_bits_tag = t;
        bus.io_in_bits_data = d;
        bus.io_in_bits_executeIndex = 2'($urandom);
        bus.io_in_bits_vxsat = 1'($urandom);
        bus.io_in_bits_exceptionFlags = 5'($urandom);
        bus.io_out_ready = r;
    endtask

    function automatic entry_t in_entry();
        return '{d: bus.io_in_bits_data, ei: bus.io_in_bits_executeIndex,
                 vx: bus.io_in_bits_vxsat, fl: bus.io_in_bits_exceptionFlags};
    endfunction

    function automatic bit model_bypass(input int slot);
`ifdef VFU_RESP_BYPASS_EN
        return bus.io_in_valid && (int'(bus.io_in_bits_tag) == slot) &&
               (exp_q[slot].size() == 0) && bus.io_out_ready[slot];
`else
        return 1'b0;
`endif
    endfunction

    // Input-side model: predict ready, then record acceptance at the clock edge
    initial begin
        bit s_rst, s_v, exp_rdy, s_byp;
        int s_t;
        entry_t s_e;
        forever begin
            @(negedge clock);
            #1;
            s_rst = !reset;
            s_v = bus.io_in_valid;
            s_t = int'(bus.io_in_bits_tag);
            s_e = in_entry();
            exp_rdy = (s_t >= TN) ? 1'b1 : (exp_q[s_t].size() != DEPTH);
            s_byp = (s_t < TN) ? model_bypass(s_t) : 1'b0;
            if (model_ok) chk("in_ready", 64'(bus.io_in_ready), 64'(exp_rdy));
            @(posedge clock);
            if (s_rst) begin
                for (int i = 0; i < TN; i++) exp_q[i].delete();
                tag_err_exp = 1'b0;
                model_ok = 1'b1;
            end else if (model_ok && s_v) begin
                if (s_t >= TN) tag_err_exp = 1'b1;
                else if (exp_rdy && !s_byp) exp_q[s_t].push_back(s_e);
            end
        end
    end

    // Output-side monitor: compare every slot head and count, pop on handshake
    initial begin
        bit m_rst, ev, byp;
        bit [TN-1:0] pops;
        entry_t e_exp, e_act;
        forever begin
            @(negedge clock);
            #1;
            m_rst = !reset;
            pops = '0;
            if (model_ok) begin
                for (int i = 0; i < TN; i++) begin
                    byp = model_bypass(i);
                    ev = (exp_q[i].size() != 0) || byp;
                    chk($sformatf("out_valid[%0d]", i), 64'(bus.io_out_valid[i]), 64'(ev));
                    chk($sformatf("count[%0d]", i), 64'(bus.io_count[i*CW +: CW]), 64'(exp_q[i].size()));
                    if (ev) begin
                        e_exp = byp ? in_entry() : exp_q[i][0];
                        e_act = '{d: bus.io_out_bits_data[i*DW +: DW],
                                  ei: bus.io_out_bits_executeIndex[i*2 +: 2],
                                  vx: bus.io_out_bits_vxsat[i],
                                  fl: bus.io_out_bits_exceptionFlags[i*5 +: 5]};
                        chk($sformatf("head[%0d]", i), 64'(e_act), 64'(e_exp));
                        if (!byp && bus.io_out_ready[i]) pops[i] = 1'b1;
                    end
                end
                chk("tagError", 64'(bus.io_tagError), 64'(tag_err_exp));
            end
            @(posedge clock);
            if (!m_rst) begin
                for (int i = 0; i < TN; i++) if (pops[i]) void'(exp_q[i].pop_front());
            end
        end
    end

    // Directed scenarios followed by randomized traffic with a mid-traffic reset
    initial begin
        reset = 1'b0;
        bus.io_in_valid = 1'b0;
        bus.io_in_bits_tag = 2'd0;
        bus.io_in_bits_data = 32'd0;
        bus.io_in_bits_executeIndex = 2'd0;
        bus.io_in_bits_vxsat = 1'b0;
        bus.io_in_bits_exceptionFlags = 5'd0;
        bus.io_out_ready = 3'b000;
        repeat (3) drive(1'b1, 1'b0, 2'd0, 32'd0, 3'b000);
        drive(1'b0, 1'b0, 2'd0, 32'd0, 3'b000);
        #2;
        chk("reset out_valid", 64'(bus.io_out_valid), 64'(3'b000));
        chk("reset out_data", 64'(bus.io_out_bits_data), 64'd0);
        chk("reset count", 64'(bus.io_count), 64'd0);

        drive(1'b0, 1'b1, 2'd2, 32'hDEAD_BEEF, 3'b000);
        drive(1'b0, 1'b0, 2'd0, 32'd0, 3'b000);
        #2;
        chk("t2 out_valid", 64'(bus.io_out_valid), 64'(3'b100));
        chk("t2 data2", 64'(bus.io_out_bits_data[2*DW +: DW]), 64'h0000_0000_DEAD_BEEF);
        chk("t2 count2", 64'(bus.io_count[2*CW +: CW]), 64'd1);
        repeat (3) drive(1'b0, 1'b0, 2'd0, 32'd0, 3'b111);

        drive(1'b0, 1'b1, 2'd1, 32'h1111_0001, 3'b000);
        drive(1'b0, 1'b1, 2'd1, 32'h1111_0002, 3'b000);
        drive(1'b0, 1'b1, 2'd1, 32'h1111_0003, 3'b000);
        #2;
        chk("t3 third ready", 64'(bus.io_in_ready), 64'd0);
        chk("t3 count1", 64'(bus.io_count[1*CW +: CW]), 64'd2);
        drive(1'b0, 1'b1, 2'd0, 32'h0000_00A0, 3'b000);
        #2;
        chk("t4 tag0 ready", 64'(bus.io_in_ready), 64'd1);
        drive(1'b0, 1'b1, 2'd1, 32'h1111_0004, 3'b010);
        #2;
        chk("t4 full no bypass", 64'(bus.io_in_ready), 64'd0);
        drive(1'b0, 1'b0, 2'd0, 32'd0, 3'b000);
        #2;
        chk("t4 count1", 64'(bus.io_count[1*CW +: CW]), 64'd1);
        chk("t4 count0", 64'(bus.io_count[0 +: CW]), 64'd1);
        repeat (3) drive(1'b0, 1'b0, 2'd0, 32'd0, 3'b111);

        drive(1'b0, 1'b1, 2'd3, 32'h0BAD_0003, 3'b000);
        #2;
        chk("t5 bad tag ready", 64'(bus.io_in_ready), 64'd1);
        drive(1'b0, 1'b0, 2'd0, 32'd0, 3'b000);
        #2;
        chk("t5 tagError", 64'(bus.io_tagError), 64'd1);
        chk("t5 no enqueue", 64'(bus.io_count), 64'd0);
        repeat (2) drive(1'b0, 1'b1, 2'd0, 32'h0000_0005, 3'b000);
        #2;
        chk("t5 tagError sticky", 64'(bus.io_tagError), 64'd1);
        repeat (3) drive(1'b0, 1'b0, 2'd0, 32'd0, 3'b111);

`ifdef VFU_RESP_BYPASS_EN
        drive(1'b0, 1'b1, 2'd0, 32'h0000_0005, 3'b001);
        #2;
        chk("t6 bypass valid0", 64'(bus.io_out_valid[0]), 64'd1);
        chk("t6 bypass data0", 64'(bus.io_out_bits_data[0 +: DW]), 64'd5);
        drive(1'b0, 1'b0, 2'd0, 32'd0, 3'b000);
        #2;
        chk("t6 count0", 64'(bus.io_count[0 +: CW]), 64'd0);
`endif

        for (int c = 0; c < 1500; c++) begin
            drive(1'b0, 1'($urandom_range(0, 3) != 0), 2'($urandom), $urandom, 3'($urandom));
            if (c == 700) begin
                for (int k = 0; k < 6; k++) drive(1'b0, 1'b1, 2'($urandom_range(0, 2)), $urandom, 3'b000);
                repeat (2) drive(1'b1, 1'b1, 2'($urandom), $urandom, 3'($urandom));
                drive(1'b0, 1'b0, 2'd0, 32'd0, 3'b000);
                #2;
                chk("t1 post-reset valid", 64'(bus.io_out_valid), 64'd0);
                chk("t1 post-reset count", 64'(bus.io_count), 64'd0);
                chk("t1 post-reset tagError", 64'(bus.io_tagError), 64'd0);
            end
        end
        repeat (4) drive(1'b0, 1'b0, 2'd0, 32'd0, 3'b111);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
